// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared definitions for the game datapath: player-turn encodings driven by
//   game_fsm, the arbiter state encoding, and a helper that folds the unused
//   turn code onto "no player turn".
//
//   Contents:
//     TURN_NONE / TURN_P1 / TURN_P2  P_turn encodings (2'd3 behaves as NONE)
//     arb_state_t                    button_arbiter FSM states
//     normalise_turn()               maps P_turn onto one of the three codes
// -----------------------------------------------------------------------------
package game_pkg;

  localparam logic [1:0] TURN_NONE = 2'd0;
  localparam logic [1:0] TURN_P1   = 2'd1;
  localparam logic [1:0] TURN_P2   = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_LOCKOUT = 1'b1
  } arb_state_t;

  // game_fsm never drives 2'd3 on purpose; if it ever appears, nobody has the
  // turn, so both players' presses are out of turn.
  function automatic logic [1:0] normalise_turn(input logic [1:0] p_turn);
    if ((p_turn == TURN_P1) || (p_turn == TURN_P2)) begin
      return p_turn;
    end
    return TURN_NONE;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Conditions one raw push-button: two-flop synchroniser, counter-based
//   debounce, and rising-edge detection of the debounced level.
//
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     raw      in   raw button level, asynchronous to clk
//     req      out  one-cycle pulse on a debounced 0->1 transition
//
//   Parameters:
//     DB_CYCLES  consecutive disagreeing cycles needed to flip the level (>=1)
//     CNT_W      debounce counter width, must hold DB_CYCLES
//
//   Timing: a raw level that rises in cycle 0 and stays high shows up as req
//   in cycle DB_CYCLES+2 (two sync stages plus DB_CYCLES of debounce).
// -----------------------------------------------------------------------------
module btn_conditioner
  import game_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic req
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic             level_prev_q;
  logic [CNT_W-1:0] db_cnt;

  // Everything resets to 1 ("pressed"): a button held through reset looks
  // like it has always been pressed, so it produces no edge until it has
  // been released for DB_CYCLES and pressed again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1      <= 1'b1;
      sync_q2      <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      db_cnt       <= '0;
    end else begin
      sync_q1      <= raw;
      sync_q2      <= sync_q1;
      level_prev_q <= level_q;

      // The counter measures how long the synchronised input has disagreed
      // with the debounced level; any agreement restarts the measurement,
      // so a glitch shorter than DB_CYCLES never reaches the level.
      if (sync_q2 != level_q) begin
        if (db_cnt == DB_LAST) begin
          level_q <= ~level_q;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Combinational edge: high only in the first cycle of a new high level.
  assign req = level_q & ~level_prev_q;

endmodule

// File: rtl/button_arbiter.sv
// -----------------------------------------------------------------------------
// button_arbiter
//   Conditions the start / player-1 / player-2 push-buttons and turns them
//   into single-cycle commands for game_fsm. Player presses are accepted only
//   when P_turn grants that player; out-of-turn presses are reported as
//   fouls. After every accepted command a lockout window ignores all
//   requests so game_fsm and the LFSR sampling can settle.
//
//   Ports:
//     clk        in   system clock
//     reset_n    in   asynchronous active-low reset
//     btn_start  in   raw start button (asynchronous)
//     btn_p1     in   raw player-1 button (asynchronous)
//     btn_p2     in   raw player-2 button (asynchronous)
//     P_turn     in   [1:0] turn from game_fsm (0 none, 1 P1, 2 P2, 3 none)
//     start      out  one-cycle start command
//     P1_in      out  one-cycle player-1 command
//     P2_in      out  one-cycle player-2 command
//     foul       out  [1:0] one-cycle out-of-turn flags (bit0 P1, bit1 P2)
//     busy       out  high for the LOCKOUT_CYCLES cycles after a command
//
//   Command interface: start/P1_in/P2_in/foul are registered fire-and-forget
//   pulses. There is no back-pressure; game_fsm must act on the cycle a pulse
//   is high. At most one of start/P1_in/P2_in is high in any cycle, and the
//   lockout that follows each command guarantees a gap of LOCKOUT_CYCLES+1
//   cycles before the next one.
//
//   Timeline for a command pulse in cycle P:
//     cycle P            : pulse high, FSM in LOCKOUT, busy low
//     cycles P+1..P+L    : busy high, requests dropped
//     cycle P+L+1        : back in IDLE, requests evaluated again
//   (requests arriving in cycles P..P+L are discarded, not queued)
// -----------------------------------------------------------------------------
module button_arbiter
  import game_pkg::*;
#(
  parameter int DB_CYCLES      = 4,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic [1:0] P_turn,
  output logic       start,
  output logic       P1_in,
  output logic       P2_in,
  output logic [1:0] foul,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES);

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic req_start;
  logic req_p1;
  logic req_p2;

  btn_conditioner #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_cond_start (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_start),
    .req     (req_start)
  );

  btn_conditioner #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_cond_p1 (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_p1),
    .req     (req_p1)
  );

  btn_conditioner #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_cond_p2 (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_p2),
    .req     (req_p2)
  );

  // ---------------------------------------------------------------------------
  // Turn decode
  // ---------------------------------------------------------------------------
  logic [1:0] turn;
  logic       grant_p1;
  logic       grant_p2;
  logic [1:0] foul_now;

  assign turn     = normalise_turn(P_turn);
  // Only one player can hold the turn, so the two grants are exclusive.
  assign grant_p1 = req_p1 && (turn == TURN_P1);
  assign grant_p2 = req_p2 && (turn == TURN_P2);
  assign foul_now = {req_p2 && !grant_p2, req_p1 && !grant_p1};

  // ---------------------------------------------------------------------------
  // Arbiter FSM. state is the observable FSM state; busy mirrors the
  // counting phase of LOCKOUT.
  // ---------------------------------------------------------------------------
  arb_state_t       state;
  logic [CNT_W-1:0] lock_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      lock_cnt <= '0;
      start    <= 1'b0;
      P1_in    <= 1'b0;
      P2_in    <= 1'b0;
      foul     <= 2'b00;
      busy     <= 1'b0;
    end else begin
      // Pulses default low so every command lasts exactly one cycle.
      start <= 1'b0;
      P1_in <= 1'b0;
      P2_in <= 1'b0;
      foul  <= 2'b00;

      case (state)
        ST_IDLE: begin
          busy     <= 1'b0;
          lock_cnt <= '0;
          if (req_start) begin
            // Start wins outright; player presses in the same cycle are
            // simply dropped and are not fouls.
            start <= 1'b1;
            state <= ST_LOCKOUT;
          end else begin
            P1_in <= grant_p1;
            P2_in <= grant_p2;
            foul  <= foul_now;
            // A foul on its own does not disturb the game timing, so only
            // an accepted command starts a lockout.
            if (grant_p1 || grant_p2) begin
              state <= ST_LOCKOUT;
            end
          end
        end

        ST_LOCKOUT: begin
          // lock_cnt is 0 in the pulse cycle; busy is raised from the next
          // cycle and held for LOCKOUT_CYCLES cycles.
          if (lock_cnt == LOCK_LAST) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            lock_cnt <= '0;
          end else begin
            busy     <= 1'b1;
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_arbiter.sv
// -----------------------------------------------------------------------------
// tb_button_arbiter
//   Directed bench for button_arbiter (DB_CYCLES=4, LOCKOUT_CYCLES=8).
//   A behavioural model predicts every output on every cycle from the
//   button/turn rules: a debounced level flips once the last DB_CYCLES
//   synchronised samples all disagree with it, a request is a 0->1 flip, and
//   lockout is tracked as a distance in clock edges from the last accepted
//   command. The model pushes one expected output word per edge into exp_q
//   and the compare process pops it half a cycle later. Directed scenarios
//   additionally check hand-computed latencies and values.
// -----------------------------------------------------------------------------
module tb_button_arbiter;
  import game_pkg::*;

  localparam int DB   = 4;
  localparam int LOCK = 8;
  localparam int CW   = 20;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_p1    = 1'b1;
  logic       btn_p2    = 1'b0;
  logic [1:0] P_turn    = TURN_P1;
  logic       start;
  logic       P1_in;
  logic       P2_in;
  logic [1:0] foul;
  logic       busy;

  initial forever #5 clk = ~clk;

  button_arbiter #(
    .DB_CYCLES      (DB),
    .LOCKOUT_CYCLES (LOCK),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_start (btn_start),
    .btn_p1    (btn_p1),
    .btn_p2    (btn_p2),
    .P_turn    (P_turn),
    .start     (start),
    .P1_in     (P1_in),
    .P2_in     (P2_in),
    .foul      (foul),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d", cyc);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Behavioural model. Bit order of one expected word:
  //   {start, P1_in, P2_in, foul[1], foul[0], busy}
  // Button sample order in hist_q: {p2, p1, start}; hist_q[k] is the raw
  // sample taken k edges ago, so hist_q[2..DB+1] are the samples that have
  // passed through the two-flop synchroniser.
  // ---------------------------------------------------------------------------
  logic [5:0] exp_q[$];
  logic [2:0] hist_q[$];
  logic [2:0] lvl;
  logic [2:0] pend;
  int         edge_n;
  int         last_acc;

  task automatic model_reset();
    hist_q.delete();
    for (int i = 0; i < DB + 2; i++) hist_q.push_back(3'b111);
    lvl      = 3'b111;
    pend     = 3'b000;
    edge_n   = 0;
    last_acc = -1000;
    exp_q.delete();
    exp_q.push_back(6'b0);
  endtask

  task automatic model_step();
    logic [2:0] old_lvl;
    logic [2:0] e;
    logic       all_diff;
    logic       s, a1, a2, b;
    logic [1:0] f;
    edge_n = edge_n + 1;
    s  = 1'b0;
    a1 = 1'b0;
    a2 = 1'b0;
    f  = 2'b00;
    // Requests raised in the cycle just ended are honoured only if at least
    // LOCK+2 edges have passed since the last accepted command.
    if (edge_n - last_acc > LOCK + 1) begin
      if (pend[0]) begin
        s = 1'b1;
      end else begin
        if (pend[1]) begin
          if (P_turn == TURN_P1) a1 = 1'b1; else f[0] = 1'b1;
        end
        if (pend[2]) begin
          if (P_turn == TURN_P2) a2 = 1'b1; else f[1] = 1'b1;
        end
      end
      if (s || a1 || a2) last_acc = edge_n;
    end
    b = (edge_n - last_acc >= 1) && (edge_n - last_acc <= LOCK);
    exp_q.push_back({s, a1, a2, f, b});

    hist_q.push_front({btn_p2, btn_p1, btn_start});
    if (hist_q.size() > DB + 2) void'(hist_q.pop_back());
    old_lvl = lvl;
    for (int bi = 0; bi < 3; bi++) begin
      all_diff = 1'b1;
      for (int k = 2; k < DB + 2; k++) begin
        e = hist_q[k];
        if (e[bi] == lvl[bi]) all_diff = 1'b0;
      end
      if (all_diff) lvl[bi] = ~lvl[bi];
    end
    pend = lvl & ~old_lvl;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard compare, every cycle on the falling edge
  // ---------------------------------------------------------------------------
  initial forever begin
    logic [5:0] exp_w;
    logic [5:0] act_w;
    @(negedge clk);
    n_cmp = n_cmp + 1;
    act_w = {start, P1_in, P2_in, foul, busy};
    if (exp_q.size() == 0) begin
      n_bad = n_bad + 1;
      $display("FAIL scoreboard cyc=%0d: got %b with no expected word queued", cyc, act_w);
    end else begin
      exp_w = exp_q.pop_front();
      if (act_w !== exp_w) begin
        n_bad = n_bad + 1;
        $display("FAIL outputs cyc=%0d {start,p1,p2,foul,busy}: got %b expected %b",
                 cyc, act_w, exp_w);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver / directed-check tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp = n_cmp + 1;
    if (act != exp_v) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return start;
      1:       return P1_in;
      2:       return P2_in;
      3:       return |foul;
      4:       return busy;
      default: return P2_in | (|foul);
    endcase
  endfunction

  // Called right after a raw input change; measures cycles to the pulse.
  task automatic wait_pulse(input int sel, input int exp_delay, input string name);
    int t0;
    int d;
    t0 = cyc;
    d  = -1;
    for (int i = 0; i < 40 && d < 0; i++) begin
      @(negedge clk);
      if (pick(sel)) d = cyc - t0;
    end
    check(name, d, exp_delay);
  endtask

  task automatic expect_none(input int sel, input int n, input string name);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pick(sel)) hits = hits + 1;
    end
    check(name, hits, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int bad;

    // Reset with btn_p1 held down.
    tick(3);
    @(negedge clk);
    check("reset_outputs", int'({start, P1_in, P2_in, foul, busy}), 0);
    tick(1);
    reset_n = 1'b1;

    // 1. Held through reset: no pulse; release, re-press -> P1_in at +7.
    expect_none(1, 20, "p1_held_through_reset");
    tick(1);
    btn_p1 = 1'b0;
    tick(10);
    btn_p1 = 1'b1;
    wait_pulse(1, 7, "p1_repress_latency");
    tick(3);
    btn_p1 = 1'b0;
    tick(14);

    // 2. Start glitch of 2 cycles, then a 10-cycle press.
    btn_start = 1'b1;
    tick(2);
    btn_start = 1'b0;
    expect_none(0, 15, "start_glitch_ignored");
    tick(1);
    btn_start = 1'b1;
    fork
      begin
        tick(10);
        btn_start = 1'b0;
      end
    join_none
    wait_pulse(0, 7, "start_press_latency");
    bad = 0;
    for (int k = 0; k < LOCK; k++) begin
      @(negedge clk);
      if (!busy) bad = bad + 1;
    end
    check("busy_high_cycles_missing", bad, 0);
    @(negedge clk);
    check("busy_low_after_lockout", int'(busy), 0);
    tick(10);

    // 3. P_turn=1, P2 pressed -> foul only.
    btn_p2 = 1'b1;
    wait_pulse(3, 7, "p2_out_of_turn_latency");
    check("p2_out_of_turn_foul", int'(foul), 2);
    check("p2_out_of_turn_no_cmd", int'(P2_in), 0);
    expect_none(4, 10, "busy_after_foul_only");
    tick(1);
    btn_p2 = 1'b0;
    tick(10);

    // 4. P1 and P2 together with P_turn=1.
    btn_p1 = 1'b1;
    btn_p2 = 1'b1;
    wait_pulse(1, 7, "p1_p2_same_cycle_latency");
    check("p1_p2_same_cycle_foul", int'(foul), 2);
    @(negedge clk);
    check("p1_p2_same_cycle_busy", int'(busy), 1);
    tick(1);
    btn_p1 = 1'b0;
    btn_p2 = 1'b0;
    tick(12);

    // 5. P2 press lands inside lockout after P1, with turn moved to P2.
    btn_p1 = 1'b1;
    wait_pulse(1, 7, "p1_before_lockout_press");
    tick(1);
    P_turn = TURN_P2;
    btn_p1 = 1'b0;
    btn_p2 = 1'b1;
    expect_none(5, 12, "p2_dropped_in_lockout");
    tick(1);
    btn_p2 = 1'b0;
    tick(10);
    btn_p2 = 1'b1;
    wait_pulse(2, 7, "p2_after_busy_latency");
    tick(2);
    btn_p2 = 1'b0;
    tick(12);

    // 6. Reset three cycles into lockout, then a fresh start press.
    btn_start = 1'b1;
    wait_pulse(0, 7, "start_before_reset");
    tick(3);
    btn_start = 1'b0;
    reset_n = 1'b0;
    #1;
    check("reset_mid_lockout", int'({start, P1_in, P2_in, foul, busy}), 0);
    tick(2);
    reset_n = 1'b1;
    tick(12);
    btn_start = 1'b1;
    wait_pulse(0, 7, "start_after_reset_latency");
    tick(2);
    btn_start = 1'b0;
    tick(12);

    // 7. P_turn=3 behaves as no turn: P1 press is a foul.
    P_turn = 2'd3;
    btn_p1 = 1'b1;
    wait_pulse(3, 7, "turn3_p1_latency");
    check("turn3_p1_foul", int'(foul), 1);
    tick(2);
    btn_p1 = 1'b0;
    tick(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
